// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse-cipher datapath stages.
//   INV_SBOX    : 256-entry inverse S-box constant table (index = input byte)
//   byte_idx    : state byte index of row r, column c (FIPS-197 column-major)
//   isb_state_t : control states of the iterative InvSubBytes stage
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } isb_state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic int byte_idx(input int r, input int c);
    return r + 4 * c;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup.
//   i_byte : byte to substitute
//   o_byte : INV_SBOX[i_byte]
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes one 4-byte column per clock using
// four shared inverse S-box lookups, with valid/ready on both sides.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : upstream handshake; in_ready is high only when idle
//   in_state        : 128-bit state, byte s[r][c] at [127-8*(r+4c) -: 8]
//   out_valid/ready : downstream handshake; out_valid high while done
//   out_state       : working register (substituted block when out_valid)
module inv_sub_bytes_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  isb_state_t   r_state;
  isb_state_t   w_state_nxt;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic [127:0] w_work_upd;
  logic         w_capture;
  logic         w_step;
  logic [7:0]   w_sb_in  [4];
  logic [7:0]   w_sb_out [4];

  // Control: outputs are pure decodes of the registered state, so neither
  // handshake input reaches an output combinationally.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (r_col == 2'd3) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Column select: the four bytes of column r_col feed the lookups.
  always_comb begin
    for (int r = 0; r < 4; r++) w_sb_in[r] = '0;
    for (int c = 0; c < 4; c++) begin
      if (r_col == 2'(c)) begin
        for (int r = 0; r < 4; r++) w_sb_in[r] = r_work[127 - 8 * byte_idx(r, c) -: 8];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .i_byte (w_sb_in[g]),
      .o_byte (w_sb_out[g])
    );
  end

  // Write-back: only the active column changes, the other 12 bytes hold.
  always_comb begin
    w_work_upd = r_work;
    for (int c = 0; c < 4; c++) begin
      if (r_col == 2'(c)) begin
        for (int r = 0; r < 4; r++) w_work_upd[127 - 8 * byte_idx(r, c) -: 8] = w_sb_out[r];
      end
    end
  end

  // Register stage: state, column counter and working register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= 2'd0;
      r_work  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_work <= in_state;
        r_col  <= 2'd0;
      end else if (w_step) begin
        r_work <= w_work_upd;
        r_col  <= r_col + 2'd1;
      end
    end
  end

  assign out_state = r_work;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
module tb_inv_sub_bytes_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_inv [256];

  inv_sub_bytes_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: inverse S-box = GF(2^8) inverse of inverse affine.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_ref();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = rotl(8'(x), 1) ^ rotl(8'(x), 3) ^ rotl(8'(x), 6) ^ 8'h05;
      ref_inv[x] = 8'h00;
      if (b != 8'h00) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(b, 8'(y)) == 8'h01) ref_inv[x] = 8'(y);
        end
      end
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = ref_inv[s[127 - 8 * i -: 8]];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block and wait (bounded) until it is taken; leaves in_valid low.
  task automatic accept(input logic [127:0] d, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_state = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_state = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 128'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got rdy=%b vld=%b st=%h need rdy=1 vld=0 st=0", i, in_ready, out_valid, out_state);
      end
    end
  endtask

  task automatic test_const();
    bit ok;
    int cyc;
    out_ready = 1'b1;
    accept({16{8'h63}}, ok);
    wait_valid(cyc);
    total++;
    if (!ok || cyc !== 4) begin
      bad++;
      $display("FAIL const63_latency got ok=%0d cyc=%0d need ok=1 cyc=4", ok, cyc);
    end
    total++;
    if (out_state !== 128'h0) begin
      bad++;
      $display("FAIL const63_data got %h need %h", out_state, 128'h0);
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL const63_release got rdy=%b vld=%b need rdy=1 vld=0", in_ready, out_valid);
    end
    accept(128'h0, ok);
    wait_valid(cyc);
    total++;
    if (!ok || cyc !== 4 || out_state !== {16{8'h52}}) begin
      bad++;
      $display("FAIL const00 got ok=%0d cyc=%0d st=%h need cyc=4 st=%h", ok, cyc, out_state, {16{8'h52}});
    end
    tick();
  endtask

  task automatic test_bytes();
    bit ok;
    int cyc;
    out_ready = 1'b1;
    accept({4{32'h7c00ff16}}, ok);
    wait_valid(cyc);
    total++;
    if (!ok || cyc !== 4 || out_state !== {4{32'h01527dff}}) begin
      bad++;
      $display("FAIL bytes_mix got cyc=%0d st=%h need cyc=4 st=%h", cyc, out_state, {4{32'h01527dff}});
    end
    tick();
    accept(128'hd42711aee0bf98f1b8b45de51e415230, ok);
    wait_valid(cyc);
    total++;
    if (!ok || out_state !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
      bad++;
      $display("FAIL fips_round got %h need %h", out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    int stall_bad;
    out_ready = 1'b0;
    accept(128'hd42711aee0bf98f1b8b45de51e415230, ok);
    wait_valid(cyc);
    in_valid = 1'b1;
    in_state = {16{8'h63}};
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
        bad++;
        stall_bad++;
        $display("FAIL stall cyc=%0d got vld=%b rdy=%b st=%h need vld=1 rdy=0 st=%h", i, out_valid, in_ready, out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_to_idle got rdy=%b vld=%b need rdy=1 vld=0", in_ready, out_valid);
    end
    tick();
    total++;
    if (in_ready !== 1'b0 || out_state !== {16{8'h63}}) begin
      bad++;
      $display("FAIL second_accept got rdy=%b st=%h need rdy=0 st=%h", in_ready, out_state, {16{8'h63}});
    end
    in_valid = 1'b0;
    wait_valid(cyc);
    total++;
    if (cyc !== 4 || out_state !== 128'h0) begin
      bad++;
      $display("FAIL second_result got cyc=%0d st=%h need cyc=4 st=0", cyc, out_state);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    int cyc;
    out_ready = 1'b1;
    accept({16{8'h00}}, ok);
    tick();
    rst = 1'b1;
    in_valid = 1'b1;
    in_state = {16{8'h11}};
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 128'h0) begin
      bad++;
      $display("FAIL mid_reset got rdy=%b vld=%b st=%h need rdy=1 vld=0 st=0", in_ready, out_valid, out_state);
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || out_state !== 128'h0) begin
      bad++;
      $display("FAIL reset_no_capture got rdy=%b st=%h need rdy=1 st=0", in_ready, out_state);
    end
    accept({16{8'h63}}, ok);
    wait_valid(cyc);
    total++;
    if (!ok || cyc !== 4 || out_state !== 128'h0) begin
      bad++;
      $display("FAIL after_reset got cyc=%0d st=%h need cyc=4 st=0", cyc, out_state);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q [$];
    logic [127:0] e;
    int sent;
    int recv;
    int cyc;
    bit fire_in;
    bit fire_out;
    sent = 0;
    recv = 0;
    cyc = 0;
    in_valid = 1'b0;
    while (recv < 100 && cyc < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra got %h need no output", out_state);
        end else begin
          e = exp_q.pop_front();
          if (out_state !== e) begin
            bad++;
            $display("FAIL stream_data idx=%0d got %h need %h", recv, out_state, e);
          end
        end
        recv++;
      end
      if (fire_in) exp_q.push_back(model(in_state));
      tick();
      cyc++;
      if (fire_in) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    total++;
    if (recv !== 100 || sent !== 100 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL stream_count got sent=%0d recv=%0d left=%0d need 100/100/0", sent, recv, exp_q.size());
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_state = '0;
    out_ready = 1'b0;
    build_ref();
    test_reset();
    test_const();
    test_bytes();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
